perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of hardware performance-event counters with snapshot-and-dump readout. It is the shared successor to per-signal ad-hoc perf counters. Each instance counts up to NUM_EVT multi-increment events per cycle and keeps sticky overflow flags. On request, or periodically, it captures all counters atomically into shadow storage and streams them out over a valid/ready port. One instance sits per subsystem (frontend, LSU, caches); the dump port feeds the simulation log or the CSR/trace collector.

## Interface
- NUM_EVT, 16, number of event channels (≥1)
- CNT_W, 32, live/shadow counter width
- INC_W, 3, per-channel increment width per cycle (multi-issue events)
- WINDOW, 0, auto-snapshot period in enabled cycles; 0 disables
- CLR_ON_SNAP, 0, 1 = delta mode: live counters restart at each snapshot
- ID_W, $clog2(NUM_EVT) (min 1), derived, dump index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global count enable (gates increments and window counter)
- evt_inc  in  NUM_EVT*INC_W  packed unsigned increments, channel i at [i*INC_W +: INC_W]
- clear  in  1  zero all live counters and overflow flags
- snap_req  in  1  request snapshot + dump
- snap_busy  out  1  dump in progress
- dump_valid  out  1  dump entry valid
- dump_ready  in  1  consumer accepts entry
- dump_id  out  ID_W  channel index of entry
- dump_value  out  CNT_W  shadow counter value
- dump_ovf  out  1  shadow overflow flag
- dump_last  out  1  entry is channel NUM_EVT-1

## Operation
- Live update per channel, each cycle, when en=1: cnt <= cnt + zero-extended inc, modulo 2^CNT_W. A carry out of CNT_W sets the sticky ovf flag.
- Priority per cycle: clear > snapshot-restart (CLR_ON_SNAP) > increment.
  - clear=1: cnt=0, ovf=0; that cycle's increments are discarded.
  - Snapshot cycle with CLR_ON_SNAP=1: cnt <= that cycle's inc (no event lost), ovf <= 0.
- Snapshot trigger: snap_req=1, or a pending auto request, while FSM is IDLE. All live cnt/ovf are copied to the shadow registers in the same edge, using the pre-increment register values.
- snap_req while BUSY: ignored, not queued.
- Auto window: the window counter counts en cycles from 0 to WINDOW-1, then wraps and sets auto_pend. auto_pend triggers a snapshot on the first IDLE cycle, then clears. Only one pending request is held; further wraps while pending are merged. clear also resets the window counter and auto_pend.
- Simultaneous clear and snapshot: the shadow captures the pre-clear values, and the live counters are zeroed.
- FSM:
  - IDLE: trigger goes to DUMP with idx=0.
  - DUMP: dump_valid=1. Outputs are idx, shadow[idx], shadow_ovf[idx], and dump_last=(idx==NUM_EVT-1). On valid&ready, idx increments; on the last entry's handshake the FSM goes to IDLE.
- snap_busy = (state==DUMP).

## Timing
- Reset values: all counters, ovf flags, shadows, window counter, auto_pend, idx = 0; state IDLE. Outputs snap_busy, dump_valid, dump_last, dump_id, dump_value, dump_ovf = 0.
- snap_req sampled at edge t gives dump_valid=1 from cycle t+1. The entry for channel k appears no earlier than t+1+k; minimum dump duration is NUM_EVT cycles.
- Outputs are registered or derived from registered state only; there is no combinational path from dump_ready to dump_valid.
- Under backpressure (dump_ready=0), dump_valid, dump_id, dump_value, dump_ovf and dump_last stay stable.
- After the last handshake at edge e, state is IDLE in cycle e+1. A snap_req in cycle e+1 is accepted, giving back-to-back dumps with a one-cycle gap.
- Live counting continues unaffected during DUMP.
- Reset asserted mid-dump: immediate return to reset values; no partial dump resumes.

## Structure
- Shared package perf_pkg holds:
  - typedef enum {IDLE, DUMP} perf_state_e
  - a packed struct perf_dump_t {id, value, ovf, last}, parameterised via localparams
  - the ID_W clog2 helper
- Sub-module perf_counter_cell holds one live counter and its ovf sticky, with clear/restart/inc priority. It is instantiated NUM_EVT times in a generate loop. Shadow storage, window logic and the FSM live in the top module.

## Test plan
- NUM_EVT=4, CNT_W=8, INC_W=2: evt0 inc=3 for 10 en cycles, then snap_req with ready=1 -> entries id0..3 = 30,0,0,0, all ovf=0, last on id3, dump takes 4 cycles.
- CNT_W=8, evt1 inc=1 for 257 cycles -> dump value 1, ovf=1. Then clear -> next dump value 0, ovf=0.
- dump_ready low for 5 cycles mid-dump -> outputs held stable. A snap_req pulse during DUMP is ignored: exactly one dump of NUM_EVT entries.
- CLR_ON_SNAP=1, evt2 inc=1 every cycle, snap_req every 20 cycles -> every dump reports 20 for id2, with no lost counts across snapshots.
- WINDOW=16, dump_ready held low so DUMP spans a window wrap -> auto_pend=1. A new snapshot occurs on the first IDLE cycle after the last handshake; only one extra dump.
- rst pulse during DUMP at idx=2 -> next cycle dump_valid=0, snap_busy=0, all counters 0. A following snap_req dumps all zeros.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance-counter bank.
package perf_pkg;

  // Dump index width; a single-channel bank still needs a 1-bit index.
  function automatic int unsigned perf_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {IDLE, DUMP} perf_state_e;

  // Default geometry of a bank; trace collectors use these to size dump records.
  localparam int unsigned PerfDefNumEvt = 16;
  localparam int unsigned PerfDefCntW   = 32;
  localparam int unsigned PerfDefIdW    = perf_id_w(PerfDefNumEvt);

  typedef struct packed {
    logic [PerfDefIdW-1:0]  id;
    logic [PerfDefCntW-1:0] value;
    logic                   ovf;
    logic                   last;
  } perf_dump_t;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, event and dump-stream signals of one perf_counter_bank.
interface perf_counter_bank_if #(
  parameter int unsigned NUM_EVT = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned INC_W   = 3,
  parameter int unsigned ID_W    = perf_pkg::perf_id_w(NUM_EVT)
);
  logic                     en;
  logic [NUM_EVT*INC_W-1:0] evt_inc;
  logic                     clear;
  logic                     snap_req;
  logic                     snap_busy;
  logic                     dump_valid;
  logic                     dump_ready;
  logic [ID_W-1:0]          dump_id;
  logic [CNT_W-1:0]         dump_value;
  logic                     dump_ovf;
  logic                     dump_last;

  // Event source / dump consumer side.
  modport master (
    output en, evt_inc, clear, snap_req, dump_ready,
    input  snap_busy, dump_valid, dump_id, dump_value, dump_ovf, dump_last
  );

  // Counter bank side.
  modport slave (
    input  en, evt_inc, clear, snap_req, dump_ready,
    output snap_busy, dump_valid, dump_id, dump_value, dump_ovf, dump_last
  );
endinterface

// File: rtl/perf_counter_cell.sv
// One live event counter with sticky overflow; priority clear > restart > increment.
module perf_counter_cell #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned INC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             restart,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   inc_ext;
  logic [CNT_W:0]   sum;

  assign inc_ext = (CNT_W + 1)'(inc);
  // Top bit of sum is the carry out of the counter width.
  assign sum     = {1'b0, cnt_q} + inc_ext;

  // Next-state: restart keeps the snapshot cycle's own events so none are lost.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (restart) begin
      cnt_d = en ? inc_ext[CNT_W-1:0] : '0;
      ovf_d = 1'b0;
    end else if (en) begin
      cnt_d = sum[CNT_W-1:0];
      ovf_d = ovf_q | sum[CNT_W];
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with atomic snapshot into shadows and a valid/ready dump stream.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT     = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned INC_W       = 3,
  parameter int unsigned WINDOW      = 0,
  parameter bit          CLR_ON_SNAP = 1'b0
) (
  input logic clk,
  input logic rst,
  perf_counter_bank_if.slave bus
);
  localparam int unsigned ID_W  = perf_id_w(NUM_EVT);
  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_EVT - 1);

  perf_state_e      state_q, state_d;
  logic [ID_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] live_cnt [NUM_EVT];
  logic [NUM_EVT-1:0] live_ovf;
  logic [CNT_W-1:0] shadow_q [NUM_EVT];
  logic [NUM_EVT-1:0] shadow_ovf_q;
  logic             auto_pend_q, auto_pend_d;
  logic             win_wrap;
  logic             trigger;
  logic             restart;
  logic             dumping;

  assign dumping = (state_q == DUMP);
  assign trigger = (state_q == IDLE) && (bus.snap_req || auto_pend_q);
  assign restart = CLR_ON_SNAP && trigger;

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_cell
    perf_counter_cell #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .clear   (bus.clear),
      .restart (restart),
      .inc     (bus.evt_inc[i*INC_W +: INC_W]),
      .cnt     (live_cnt[i]),
      .ovf     (live_ovf[i])
    );
  end

  // Shadow capture of pre-update live values on the trigger edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVT; i++) shadow_q[i] <= '0;
      shadow_ovf_q <= '0;
    end else if (trigger) begin
      for (int i = 0; i < NUM_EVT; i++) shadow_q[i] <= live_cnt[i];
      shadow_ovf_q <= live_ovf;
    end
  end

  if (WINDOW > 0) begin : g_win
    logic [WIN_W-1:0] win_q;

    assign win_wrap = bus.en && (win_q == WIN_W'(WINDOW - 1));

    // Window counter advances on enabled cycles only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        win_q <= '0;
      end else if (bus.clear) begin
        win_q <= '0;
      end else if (bus.en) begin
        win_q <= win_wrap ? '0 : win_q + WIN_W'(1);
      end
    end
  end else begin : g_no_win
    assign win_wrap = 1'b0;
  end

  // Single pending auto request; a new wrap wins over consumption in the same cycle.
  always_comb begin
    auto_pend_d = auto_pend_q;
    if (bus.clear) begin
      auto_pend_d = 1'b0;
    end else if (win_wrap) begin
      auto_pend_d = 1'b1;
    end else if (trigger) begin
      auto_pend_d = 1'b0;
    end
  end

  // FSM next-state: walk idx through the shadows, one entry per handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        if (bus.dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ID_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, index and pending-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      auto_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      auto_pend_q <= auto_pend_d;
    end
  end

  // Dump outputs come from registered state only and read zero while idle.
  assign bus.snap_busy  = dumping;
  assign bus.dump_valid = dumping;
  assign bus.dump_id    = dumping ? idx_q : '0;
  assign bus.dump_value = dumping ? shadow_q[idx_q] : '0;
  assign bus.dump_ovf   = dumping && shadow_ovf_q[idx_q];
  assign bus.dump_last  = dumping && (idx_q == LastIdx);
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations against a sum-since-clear reference model.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned CW      = 8;
  localparam int unsigned IW      = 2;
  localparam int unsigned IncBits = N * IW;
  localparam int          ND      = 3;
  localparam int          MaxWait = 200;
  localparam longint      Mod     = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clear = 1'b0, snap = 1'b0, rdy = 1'b0;
  logic [IncBits-1:0] inc = '0;

  always #5 clk = ~clk;

  perf_counter_bank_if #(.NUM_EVT(N), .CNT_W(CW), .INC_W(IW)) bus_a ();
  perf_counter_bank_if #(.NUM_EVT(N), .CNT_W(CW), .INC_W(IW)) bus_b ();
  perf_counter_bank_if #(.NUM_EVT(N), .CNT_W(CW), .INC_W(IW)) bus_c ();

  assign bus_a.en = en;  assign bus_a.evt_inc = inc;  assign bus_a.clear = clear;
  assign bus_a.snap_req = snap;  assign bus_a.dump_ready = rdy;
  assign bus_b.en = en;  assign bus_b.evt_inc = inc;  assign bus_b.clear = clear;
  assign bus_b.snap_req = snap;  assign bus_b.dump_ready = rdy;
  assign bus_c.en = en;  assign bus_c.evt_inc = inc;  assign bus_c.clear = clear;
  assign bus_c.snap_req = snap;  assign bus_c.dump_ready = rdy;

  // a: plain, b: delta mode, c: auto window of 16.
  perf_counter_bank #(.NUM_EVT(N), .CNT_W(CW), .INC_W(IW), .WINDOW(0), .CLR_ON_SNAP(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  perf_counter_bank #(.NUM_EVT(N), .CNT_W(CW), .INC_W(IW), .WINDOW(0), .CLR_ON_SNAP(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  perf_counter_bank #(.NUM_EVT(N), .CNT_W(CW), .INC_W(IW), .WINDOW(16), .CLR_ON_SNAP(1'b0))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  logic [ND-1:0] o_valid, o_busy, o_ovf, o_last;
  logic [1:0]    o_id  [ND];
  logic [CW-1:0] o_val [ND];

  assign o_valid = {bus_c.dump_valid, bus_b.dump_valid, bus_a.dump_valid};
  assign o_busy  = {bus_c.snap_busy, bus_b.snap_busy, bus_a.snap_busy};
  assign o_ovf   = {bus_c.dump_ovf, bus_b.dump_ovf, bus_a.dump_ovf};
  assign o_last  = {bus_c.dump_last, bus_b.dump_last, bus_a.dump_last};
  assign o_id[0] = bus_a.dump_id;     assign o_id[1] = bus_b.dump_id;
  assign o_id[2] = bus_c.dump_id;
  assign o_val[0] = bus_a.dump_value; assign o_val[1] = bus_b.dump_value;
  assign o_val[2] = bus_c.dump_value;

  // Reference model: each counter is the plain sum of events since its last clear/restart.
  int     win_cfg [ND] = '{0, 0, 16};
  bit     cos_cfg [ND] = '{1'b0, 1'b1, 1'b0};
  string  nm      [ND] = '{"a", "b", "c"};
  longint tot     [ND][N];
  bit     m_busy  [ND];
  int     m_idx   [ND];
  int     sh_val  [ND][N];
  bit     sh_ovf  [ND][N];
  int     en_cnt  [ND];
  bit     pend    [ND];

  // Entries actually handed over by each DUT.
  int got_val  [ND][N];
  int got_ovf  [ND][N];
  int got_last [ND][N];
  int entries    [ND] = '{0, 0, 0};
  int dumps_done [ND] = '{0, 0, 0};

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int ch = 0; ch < N; ch++) begin
        tot[d][ch]    = 0;
        sh_val[d][ch] = 0;
        sh_ovf[d][ch] = 1'b0;
      end
      m_busy[d] = 1'b0;
      m_idx[d]  = 0;
      en_cnt[d] = 0;
      pend[d]   = 1'b0;
    end
  endtask

  task automatic clr_got(input int d);
    for (int ch = 0; ch < N; ch++) begin
      got_val[d][ch]  = -1;
      got_ovf[d][ch]  = -1;
      got_last[d][ch] = -1;
    end
  endtask

  // Compare current outputs with the model and log handshakes.
  task automatic score();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s.valid", nm[d]), o_valid[d], m_busy[d]);
      check($sformatf("%s.busy", nm[d]), o_busy[d], m_busy[d]);
      if (m_busy[d]) begin
        check($sformatf("%s.id", nm[d]), o_id[d], m_idx[d]);
        check($sformatf("%s.value[%0d]", nm[d], m_idx[d]), o_val[d], sh_val[d][m_idx[d]]);
        check($sformatf("%s.ovf[%0d]", nm[d], m_idx[d]), o_ovf[d], sh_ovf[d][m_idx[d]]);
        check($sformatf("%s.last[%0d]", nm[d], m_idx[d]), o_last[d], m_idx[d] == N - 1);
      end
      if (o_valid[d] && rdy) begin
        got_val[d][o_id[d]]  = int'(o_val[d]);
        got_ovf[d][o_id[d]]  = int'(o_ovf[d]);
        got_last[d][o_id[d]] = int'(o_last[d]);
        entries[d]++;
        if (o_last[d]) dumps_done[d]++;
      end
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      bit trig;
      trig = !m_busy[d] && (snap || pend[d]);
      if (trig) begin
        for (int ch = 0; ch < N; ch++) begin
          sh_val[d][ch] = int'(tot[d][ch] % Mod);
          sh_ovf[d][ch] = tot[d][ch] >= Mod;
        end
        m_busy[d] = 1'b1;
        m_idx[d]  = 0;
      end else if (m_busy[d] && rdy) begin
        if (m_idx[d] == N - 1) begin
          m_busy[d] = 1'b0;
          m_idx[d]  = 0;
        end else begin
          m_idx[d]++;
        end
      end
      for (int ch = 0; ch < N; ch++) begin
        longint v;
        v = longint'(inc[ch*IW +: IW]);
        if (clear) tot[d][ch] = 0;
        else if (trig && cos_cfg[d]) tot[d][ch] = en ? v : 0;
        else if (en) tot[d][ch] += v;
      end
      if (clear) begin
        en_cnt[d] = 0;
        pend[d]   = 1'b0;
      end else begin
        if (en) en_cnt[d]++;
        if (win_cfg[d] != 0 && en && (en_cnt[d] % win_cfg[d]) == 0) pend[d] = 1'b1;
        else if (trig) pend[d] = 1'b0;
      end
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    score();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int d, output int n);
    n = 0;
    while (o_busy[d] && n < MaxWait) begin
      tick();
      n++;
    end
    if (n >= MaxWait) check($sformatf("%s.idle_timeout", nm[d]), o_busy[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int base_d, base_e;
    logic [12:0] held, cur;

    model_reset();
    for (int d = 0; d < ND; d++) clr_got(d);
    #12;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s.rst_valid", nm[d]), o_valid[d], 0);
      check($sformatf("%s.rst_busy", nm[d]), o_busy[d], 0);
      check($sformatf("%s.rst_id", nm[d]), o_id[d], 0);
      check($sformatf("%s.rst_value", nm[d]), o_val[d], 0);
      check($sformatf("%s.rst_ovf", nm[d]), o_ovf[d], 0);
      check($sformatf("%s.rst_last", nm[d]), o_last[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Channel 0 adds 3 for ten cycles, then one dump at full rate.
    en = 1'b1; rdy = 1'b1; inc = IncBits'(8'h03);
    repeat (10) tick();
    inc = '0; clr_got(0); base_e = entries[0];
    snap = 1'b1; tick(); snap = 1'b0;
    check("t1.valid_next", o_valid[0], 1);
    wait_idle(0, n);
    check("t1.cycles", n, N);
    check("t1.entries", entries[0] - base_e, N);
    check("t1.val0", got_val[0][0], 30);
    check("t1.val1", got_val[0][1], 0);
    check("t1.val2", got_val[0][2], 0);
    check("t1.val3", got_val[0][3], 0);
    check("t1.ovf0", got_ovf[0][0], 0);
    check("t1.last0", got_last[0][0], 0);
    check("t1.last3", got_last[0][3], 1);

    // Channel 1 wraps an 8-bit counter once; clear then removes value and flag.
    clear = 1'b1; tick(); clear = 1'b0;
    inc = IncBits'(8'h04);
    repeat (257) tick();
    inc = '0; clr_got(0);
    snap = 1'b1; tick(); snap = 1'b0;
    wait_idle(0, n);
    check("t2.val1", got_val[0][1], 1);
    check("t2.ovf1", got_ovf[0][1], 1);
    check("t2.val0", got_val[0][0], 0);
    clear = 1'b1; tick(); clear = 1'b0;
    clr_got(0);
    snap = 1'b1; tick(); snap = 1'b0;
    wait_idle(0, n);
    check("t2.clr_val1", got_val[0][1], 0);
    check("t2.clr_ovf1", got_ovf[0][1], 0);

    // Backpressure mid-dump with a stray request that must not queue.
    inc = IncBits'($urandom);
    repeat (7) tick();
    inc = '0; base_d = dumps_done[0]; base_e = entries[0];
    snap = 1'b1; tick(); snap = 1'b0;
    tick(); tick();
    rdy = 1'b0;
    held = {o_valid[0], o_last[0], o_ovf[0], o_id[0], o_val[0]};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) snap = 1'b1;
      tick();
      snap = 1'b0;
      cur = {o_valid[0], o_last[0], o_ovf[0], o_id[0], o_val[0]};
      check($sformatf("t3.hold%0d", i), cur, held);
    end
    rdy = 1'b1;
    wait_idle(0, n);
    repeat (3) tick();
    check("t3.one_dump", dumps_done[0] - base_d, 1);
    check("t3.entries", entries[0] - base_e, N);
    check("t3.no_requeue", o_valid[0], 0);

    // Delta mode: channel 2 counts every cycle, snapshot every 20 cycles.
    clear = 1'b1; tick(); clear = 1'b0;
    inc = IncBits'(8'h10);
    repeat (20) tick();
    for (int k = 0; k < 4; k++) begin
      clr_got(1);
      snap = 1'b1; tick(); snap = 1'b0;
      repeat (19) tick();
      check($sformatf("t4.delta%0d", k), got_val[1][2], 20);
      check($sformatf("t4.ovf%0d", k), got_ovf[1][2], 0);
    end

    // Window wrap during a stalled dump yields exactly one follow-up dump.
    en = 1'b0; inc = IncBits'($urandom);
    clear = 1'b1; tick(); clear = 1'b0;
    wait_idle(2, n);
    base_d = dumps_done[2];
    rdy = 1'b0; en = 1'b1;
    snap = 1'b1; tick(); snap = 1'b0;
    repeat (20) tick();
    rdy = 1'b1;
    repeat (N) tick();
    check("t5.gap", o_busy[2], 0);
    tick();
    check("t5.auto", o_valid[2], 1);
    en = 1'b0;
    wait_idle(2, n);
    repeat (5) tick();
    check("t5.count", dumps_done[2] - base_d, 2);

    // Reset in the middle of a dump at index 2.
    en = 1'b1; inc = IncBits'($urandom); rdy = 1'b1;
    repeat (5) tick();
    inc = '0;
    wait_idle(0, n);
    snap = 1'b1; tick(); snap = 1'b0;
    tick(); tick();
    check("t6.idx_before", o_id[0], 2);
    rst = 1'b1;
    #1;
    check("t6.valid", o_valid[0], 0);
    check("t6.busy", o_busy[0], 0);
    check("t6.id", o_id[0], 0);
    check("t6.value", o_val[0], 0);
    model_reset();
    #1 rst = 1'b0;
    clr_got(0);
    snap = 1'b1; tick(); snap = 1'b0;
    wait_idle(0, n);
    for (int ch = 0; ch < N; ch++) begin
      check($sformatf("t6.zero_val%0d", ch), got_val[0][ch], 0);
      check($sformatf("t6.zero_ovf%0d", ch), got_ovf[0][ch], 0);
    end

    // Random traffic on all inputs, scored cycle by cycle.
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      inc   = IncBits'($urandom);
      clear = ($urandom_range(0, 31) == 0);
      snap  = ($urandom_range(0, 5) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      tick();
    end
    en = 1'b0; clear = 1'b0; snap = 1'b0; rdy = 1'b1;
    for (int d = 0; d < ND; d++) wait_idle(d, n);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
